serial_deframer: RTL and testbench
==================================

SERIAL_DEFRAMER -- requirements
Module: serial_deframer

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two, at least 2.
REQ-003 Parameter SYNC, default 4'b1011: 4-bit sync pattern, first-received bit at the MSB.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low; reset==0 at a rising clk edge resets the block.
REQ-006 in  input  1  serial bit stream from the upstream FSM output, one bit sampled every clk.
REQ-007 out_data  output  DATA_W  payload at the FIFO head; the first-received bit is the MSB.
REQ-008 out_valid  output  1  FIFO not empty.
REQ-009 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-010 parity_err_cnt  output  8  count of frames dropped for parity error; saturates at 255.
REQ-011 overflow  output  1  sticky flag: a good frame was dropped because the FIFO was full.
REQ-012 busy  output  1  1 whenever the FSM is not in HUNT.

Function
REQ-013 FSM states: HUNT, DATA, PARITY.
REQ-014 HUNT: a 4-bit window register shifts in `in` every cycle; when {window[2:0], in} == SYNC, the next state is DATA with bit_cnt=0.
REQ-015 DATA: shift `in` into the payload register each cycle and increment bit_cnt; on the cycle bit_cnt==DATA_W-1, the next state is PARITY.
REQ-016 PARITY: `in` is the even-parity bit; the frame is good when XOR(payload, in)==0. The next state is always HUNT, with window cleared to 0.
REQ-017 Sync detection is inactive in DATA and PARITY; payload bits matching SYNC are ignored.
REQ-018 Good frame with FIFO not full, or full with a pop in the same cycle: push the payload in the PARITY cycle.
REQ-019 Good frame with FIFO full and no pop in the same cycle: drop the payload and set overflow=1.
REQ-020 Bad-parity frame: drop the payload and increment parity_err_cnt unless it is already 255.
REQ-021 Push latency: the payload appears on out_data/out_valid on the cycle after the parity bit is sampled, when the FIFO was empty.
REQ-022 FIFO is first-in first-out; a pop occurs on each cycle with out_valid && out_ready.
REQ-023 Simultaneous push and pop leaves occupancy unchanged.
REQ-024 A pop when empty is a no-op.
REQ-025 Pointers wrap modulo FIFO_DEPTH.
REQ-026 out_data and out_valid are stable while out_valid && !out_ready.
REQ-027 out_data comes from a register or array read with no combinational path from `in`.
REQ-028 overflow stays 1 until reset; parity_err_cnt changes only as in REQ-020 and REQ-029.

Reset
REQ-029 While reset==0 at a clk edge: state=HUNT, window=0, bit_cnt=0, payload=0, FIFO emptied, out_valid=0, out_data=0, parity_err_cnt=0, overflow=0, busy=0.
REQ-030 Reset mid-frame, in DATA or PARITY, discards the partial frame with no push and no counter change; hunting restarts on the first cycle after reset returns to 1.
REQ-031 The first `in` bit sampled after reset release is the first bit considered for sync.

Verification
REQ-032 Good frame, out_ready=1: in = 1,0,1,1 then A5 as 1,0,1,0,0,1,0,1 then parity 0 -> out_valid=1 and out_data=8'hA5 exactly one cycle after the parity bit; parity_err_cnt=0; busy=1 from the first data-bit cycle through the parity cycle.
REQ-033 Bad parity: same stimulus with parity bit 1 -> out_valid stays 0, parity_err_cnt=1; a following good 8'h3C frame is delivered.
REQ-034 Backpressure/overflow: out_ready=0, send 5 good frames 01,02,03,04,05 -> overflow=1 after the 5th. Then raise out_ready -> reads give 01,02,03,04 in order, then out_valid=0.
REQ-035 Full with a concurrent pop: FIFO full, out_ready=1 on the parity cycle of frame 8'h77 -> 8'h77 is accepted, overflow stays 0, occupancy stays 4.
REQ-036 Reset mid-frame: reset=0 after 3 data bits, then release and send a good 8'h5A frame -> only 8'h5A is delivered, counters are 0, busy=0 in the cycle after reset.
REQ-037 Saturation: 260 bad-parity frames -> parity_err_cnt=255 and stays at 255.

Source files
------------

// File: rtl/serial_deframer.sv
// Serial deframer: hunts for a 4-bit sync word, collects a DATA_W-bit payload
// MSB-first, checks even parity, and queues good payloads in a small FIFO.
// Parity failures are counted (saturating); good frames lost to a full FIFO
// raise a sticky overflow flag.
module serial_deframer #(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [3:0]  SYNC       = 4'b1011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        parity_err_cnt,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

  state_t              state_q, state_d;
  logic [3:0]          window_q, window_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic [7:0]          perr_q, perr_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                push;
  logic                pop;
  logic                fifo_full;

  assign out_valid      = (occ_q != '0);
  assign out_data       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign parity_err_cnt = perr_q;
  assign overflow       = overflow_q;
  assign busy           = busy_q;
  assign fifo_full      = (occ_q == FULL_OCC);
  assign pop            = out_valid && out_ready;

  // Next-state logic for the framing FSM, error counters and FIFO pointers.
  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    bit_cnt_d  = bit_cnt_q;
    payload_d  = payload_q;
    perr_d     = perr_q;
    overflow_d = overflow_q;
    push       = 1'b0;

    case (state_q)
      HUNT: begin
        window_d = {window_q[2:0], in};
        if ({window_q[2:0], in} == SYNC) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        payload_d = {payload_q[DATA_W-2:0], in};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        state_d  = HUNT;
        window_d = '0;
        if ((^{payload_q, in}) == 1'b0) begin
          // A pop in the same cycle frees the slot this push needs.
          if (!fifo_full || pop) begin
            push = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (perr_q != 8'hFF) begin
          perr_d = perr_q + 8'd1;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    busy_d   = (state_d != HUNT);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= HUNT;
      window_q   <= '0;
      bit_cnt_q  <= '0;
      payload_q  <= '0;
      perr_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      bit_cnt_q  <= bit_cnt_d;
      payload_q  <= payload_d;
      perr_q     <= perr_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // FIFO storage; the payload register already holds the full frame on the parity cycle.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= payload_q;
    end
  end

endmodule

// File: tb/tb_serial_deframer.sv
// Directed bench for serial_deframer: framing, parity, backpressure,
// overflow, mid-frame reset and error-counter saturation.
module tb_serial_deframer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] parity_err_cnt;
  logic       overflow;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  serial_deframer #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC(4'b1011)) dut (
    .clk            (clk),
    .reset          (reset),
    .in             (in),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .parity_err_cnt (parity_err_cnt),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in = b;
    tick();
  endtask

  // Sync word, payload MSB first, then parity (inverted when bad=1).
  task automatic send_frame(input logic [7:0] d, input logic bad, input logic pop_par);
    logic [3:0] s;
    s = 4'b1011;
    for (int i = 3; i >= 0; i--) send_bit(s[i]);
    check("busy_first_data", 32'(busy), 1);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    check("busy_parity", 32'(busy), 1);
    if (pop_par) out_ready = 1'b1;
    send_bit((^d) ^ bad);
    if (pop_par) out_ready = 1'b0;
    check("busy_after", 32'(busy), 0);
    in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_b = '{8'h22, 8'h33, 8'h44, 8'h77};

    out_ready = 1'b0;
    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_perr", 32'(parity_err_cnt), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);

    // Good A5 frame with consumer ready.
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0);
    check("a5_valid", 32'(out_valid), 1);
    check("a5_data", 32'(out_data), 32'h A5);
    check("a5_perr", 32'(parity_err_cnt), 0);
    tick();
    check("a5_popped", 32'(out_valid), 0);

    // Bad parity, then good 3C.
    send_frame(8'hA5, 1'b1, 1'b0);
    check("bad_valid", 32'(out_valid), 0);
    check("bad_perr", 32'(parity_err_cnt), 1);
    send_frame(8'h3C, 1'b0, 1'b0);
    check("3c_valid", 32'(out_valid), 1);
    check("3c_data", 32'(out_data), 32'h3C);
    tick();
    check("3c_popped", 32'(out_valid), 0);

    // Backpressure and overflow.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
    check("ovf_before", 32'(overflow), 0);
    send_frame(8'h05, 1'b0, 1'b0);
    check("ovf_after", 32'(overflow), 1);
    tick();
    tick();
    check("ovf_sticky", 32'(overflow), 1);
    check("full_head_stable", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(out_valid), 1);
      check("drain_data", 32'(out_data), 32'(exp_a[i]));
      tick();
    end
    check("drain_empty", 32'(out_valid), 0);

    // Full FIFO with a pop on the parity cycle.
    out_ready = 1'b0;
    do_reset();
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b1);
    check("cpop_ovf", 32'(overflow), 0);
    check("cpop_head", 32'(out_data), 32'h22);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("cpop_valid", 32'(out_valid), 1);
      check("cpop_data", 32'(out_data), 32'(exp_b[i]));
      tick();
    end
    check("cpop_empty", 32'(out_valid), 0);

    // Reset after three data bits.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    tick();
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    reset = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    check("5a_valid", 32'(out_valid), 1);
    check("5a_data", 32'(out_data), 32'h5A);
    check("5a_perr", 32'(parity_err_cnt), 0);
    check("5a_ovf", 32'(overflow), 0);
    tick();
    check("5a_popped", 32'(out_valid), 0);

    // Saturating parity error counter.
    for (int i = 1; i <= 260; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 260)
        check("sat_perr", 32'(parity_err_cnt), (i > 255) ? 255 : i);
    end
    check("sat_valid", 32'(out_valid), 0);
    tick();
    check("sat_hold", 32'(parity_err_cnt), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
